// File: rtl/median_filter_fifo_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared constants and types for the sliding-window median filter.
//   DATA_W : sample / median width (unsigned)
//   WIN    : window length (odd, >= 3)
//   AGE_W  : width of the per-cell age tag
//   MID    : index of the median in the sorted cell array
//   cell_t : one sorted slot, sample value plus its age (0 = newest)
// -----------------------------------------------------------------------------
package median_pkg;

   localparam int DATA_W = 16;
   localparam int WIN    = 5;
   localparam int AGE_W  = $clog2(WIN);
   localparam int MID    = (WIN - 1) / 2;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic [AGE_W-1:0]  age;
   } cell_t;

endpackage : median_pkg

// File: rtl/median_filter_fifo_if.sv
// -----------------------------------------------------------------------------
// median_filter_fifo_if
// Sample / median bus of the median filter.
//   X            : input sample, held stable for two clocks per sample
//   median       : registered median of the current window
//   median_valid : present only when MEDIAN_VALID_EN is defined
// Modports: master drives samples (source side), slave is the filter.
// -----------------------------------------------------------------------------
interface median_filter_fifo_if;
   import median_pkg::*;

   logic [DATA_W-1:0] X;
   logic [DATA_W-1:0] median;

`ifdef MEDIAN_VALID_EN
   logic              median_valid;

   modport master (output X, input  median, input  median_valid);
   modport slave  (input  X, output median, output median_valid);
`else
   modport master (output X, input  median);
   modport slave  (input  X, output median);
`endif

endinterface : median_filter_fifo_if

// File: rtl/median_filter_fifo_cell.sv
// -----------------------------------------------------------------------------
// median_cell
// One slot of the sorted window. Each update evicts the oldest sample and
// inserts the new one; every slot picks its next contents from itself, its
// lower neighbour (left), its upper neighbour (right) or the new sample.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   update_i        : perform the evict/insert on this edge
//   x_i             : sample being inserted
//   left_i/right_i  : contents of slots index-1 / index+1 (tied off at ends)
//   gt_left_i/right_i : neighbours' "value > x_i" flags (ends tied 0 / 1)
//   ev_below_i      : the oldest sample sits in a slot below this one
//   cell_o          : current slot contents
//   gt_o            : this slot's value > x_i
//   ev_below_o      : ev_below_i or this slot is the oldest (chain upward)
// -----------------------------------------------------------------------------
module median_cell
   import median_pkg::*;
#(
   parameter int INDEX = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              update_i,
   input  logic [DATA_W-1:0] x_i,
   input  cell_t             left_i,
   input  cell_t             right_i,
   input  logic              gt_left_i,
   input  logic              gt_right_i,
   input  logic              ev_below_i,
   output cell_t             cell_o,
   output logic              gt_o,
   output logic              ev_below_o
);

   cell_t cell_q, cell_d;
   logic  evict;
   logic  gt_own;

   // After removing the oldest sample the remaining WIN-1 values form a
   // sorted list R; this slot needs R[INDEX-1] (lo) and R[INDEX] (hi).
   cell_t lo, hi;
   logic  gt_lo, gt_hi;

   // The two per-cell comparators.
   assign evict  = (cell_q.age == AGE_W'(WIN - 1));
   assign gt_own = (cell_q.value > x_i);

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      lo    = left_i;
      gt_lo = gt_left_i;
      hi    = cell_q;
      gt_hi = gt_own;
      if (ev_below_i) begin
         // Hole is below: everything at or above shifts down by one.
         lo    = cell_q;
         gt_lo = gt_own;
         hi    = right_i;
         gt_hi = gt_right_i;
      end else if (evict) begin
         // Hole is this slot: the upper neighbour fills it.
         hi    = right_i;
         gt_hi = gt_right_i;
      end

      // New sample lands above every value <= x_i (equal values: new after
      // old). R[INDEX] <= x : slot stays below the insert point -> take hi.
      // R[INDEX-1] > x      : slot is above the insert point -> take lo.
      // Otherwise this slot is the insert point.
      cell_d = cell_q;
      if (update_i) begin
         if (!gt_hi) begin
            cell_d.value = hi.value;
            cell_d.age   = hi.age + 1'b1;
         end else if (gt_lo) begin
            cell_d.value = lo.value;
            cell_d.age   = lo.age + 1'b1;
         end else begin
            cell_d.value = x_i;
            cell_d.age   = '0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all slots
   // sample their neighbours' old contents on the same edge.
   // NOTE: the slots are reset explicitly: the window must start as WIN zeros
   // with a valid age permutation, otherwise no slot would ever be evicted.
   always_ff @(posedge clk) begin
      if (reset) begin
         cell_q.value <= '0;
         cell_q.age   <= AGE_W'(INDEX);
      end else begin
         cell_q <= cell_d;
      end
   end

   assign cell_o     = cell_q;
   assign gt_o       = gt_own;
   assign ev_below_o = ev_below_i | evict;

endmodule : median_cell

// File: rtl/median_filter_fifo.sv
// -----------------------------------------------------------------------------
// median_filter_fifo
// Streaming sliding-window median filter. One sample accepted every two
// clocks: phase 0 captures X, phase 1 evicts the oldest sample from the
// sorted cell array, inserts the captured one, and the middle cell becomes
// the new median.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : median_filter_fifo_if.slave (X in, median out,
//           median_valid out when MEDIAN_VALID_EN is defined)
// Optional feature: define MEDIAN_VALID_EN to add median_valid, a one-clock
// pulse on every update once WIN samples have been accepted since reset.
// -----------------------------------------------------------------------------
module median_filter_fifo
   import median_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   median_filter_fifo_if.slave   bus
);

   logic              phase_q, phase_d;
   logic [DATA_W-1:0] x_q, x_d;

   cell_t cell_q   [WIN];
   logic  gt       [WIN];
   // Padded neighbour views: index k+1 is slot k, ends are tie-offs.
   cell_t cell_ext [WIN+2];
   logic  gt_ext   [WIN+2];
   // ev_chain[k] = oldest sample sits in a slot below k.
   logic  ev_chain [WIN+1];

   always_comb begin
      phase_d = ~phase_q;
      x_d     = x_q;
      if (!phase_q) begin
         x_d = bus.X;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= 1'b0;
         x_q     <= '0;
      end else begin
         phase_q <= phase_d;
         x_q     <= x_d;
      end
   end

   // Ends: nothing below slot 0 (never "greater"), nothing above the top
   // slot (treated as "greater" so it is never pulled down).
   assign cell_ext[0]     = '0;
   assign cell_ext[WIN+1] = '0;
   assign gt_ext[0]       = 1'b0;
   assign gt_ext[WIN+1]   = 1'b1;
   assign ev_chain[0]     = 1'b0;

   for (genvar i = 0; i < WIN; i++) begin : g_cell
      median_cell #(
         .INDEX (i)
      ) u_cell (
         .clk        (clk),
         .reset      (reset),
         .update_i   (phase_q),
         .x_i        (x_q),
         .left_i     (cell_ext[i]),
         .right_i    (cell_ext[i+2]),
         .gt_left_i  (gt_ext[i]),
         .gt_right_i (gt_ext[i+2]),
         .ev_below_i (ev_chain[i]),
         .cell_o     (cell_q[i]),
         .gt_o       (gt[i]),
         .ev_below_o (ev_chain[i+1])
      );
      assign cell_ext[i+1] = cell_q[i];
      assign gt_ext[i+1]   = gt[i];
   end

   // Exactly one slot holds the oldest sample whenever an update happens.
   always_ff @(posedge clk) begin
      if (!reset && phase_q) begin
         assert (ev_chain[WIN]);
      end
   end

   // The middle slot is itself a register loaded on the update edge with the
   // post-update middle value, so it serves directly as the median register.
   assign bus.median = cell_q[MID].value;

`ifdef MEDIAN_VALID_EN
   localparam int CNT_W = $clog2(WIN + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;

   // cnt_q counts accepted samples since reset, saturating at WIN.
   always_comb begin
      cnt_d   = cnt_q;
      valid_d = 1'b0;
      if (phase_q) begin
         valid_d = (cnt_q >= CNT_W'(WIN - 1));
         if (cnt_q != CNT_W'(WIN)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign bus.median_valid = valid_q;
`endif

endmodule : median_filter_fifo

// File: tb/tb_median_filter_fifo.sv
// -----------------------------------------------------------------------------
// tb_median_filter_fifo
// Scoreboarded bench for median_filter_fifo. The driver applies samples (each
// held two clocks), updates a queue-based window model and pushes the expected
// median; a monitor pops and compares after every update edge.
// -----------------------------------------------------------------------------
module tb_median_filter_fifo;
   import median_pkg::*;

   logic clk;
   logic reset;

   median_filter_fifo_if bus ();

   median_filter_fifo dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] med;
      logic              vld;
   } exp_t;

   exp_t        sb[$];
   int unsigned win_q[$];
   int unsigned accepted;
   int          n_pass  = 0;
   int          n_total = 0;
   bit          tb_phase = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   // Reference window: plain FIFO of the last WIN samples, sorted on demand.
   function automatic void model_reset();
      win_q = {};
      for (int i = 0; i < WIN; i++) win_q.push_back(0);
      accepted = 0;
   endfunction

   task automatic issue(input logic [DATA_W-1:0] s);
      int unsigned srt[$];
      exp_t        e;
      bus.X = s;
      void'(win_q.pop_front());
      win_q.push_back(int'(s));
      accepted++;
      srt = win_q;
      srt.sort();
      e.med = DATA_W'(srt[MID]);
      e.vld = (accepted >= WIN);
      sb.push_back(e);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Sample is captured, then reset hits before the update edge: the sample
   // must vanish and the filter must come back in its reset state.
   task automatic reset_mid_sample(input logic [DATA_W-1:0] s);
      bus.X = s;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_median", bus.median, 0);
`ifdef MEDIAN_VALID_EN
      check("midreset_valid", bus.median_valid, 0);
`endif
      reset = 1'b0;
      model_reset();
   endtask

   // Expected phase: 0 = next edge captures, 1 = next edge updates.
   always @(posedge clk) begin
      if (reset) tb_phase <= 1'b0;
      else       tb_phase <= ~tb_phase;
   end

   // Monitor
   initial begin
      bit   upd;
      exp_t e;
      forever begin
         @(posedge clk);
         upd = !reset && tb_phase;
         @(negedge clk);
         if (upd) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL sb_underflow: update with no expected entry (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check("median", bus.median, e.med);
`ifdef MEDIAN_VALID_EN
               check("median_valid", bus.median_valid, e.vld);
`endif
            end
         end
`ifdef MEDIAN_VALID_EN
         else begin
            check("valid_idle", bus.median_valid, 0);
         end
`endif
      end
   end

   // Driver
   initial begin
      logic [DATA_W-1:0] dir_a [19];
      logic [DATA_W-1:0] s;
      int                k;

      dir_a = '{64, 62, 76, 76, 121,
                79, 83, 80, 48, 88,
                63, 91, 90, 23,
                5, 5, 5, 5, 5};

      reset = 1'b1;
      bus.X = '0;
      repeat (2) @(negedge clk);
      check("reset_median", bus.median, 0);
`ifdef MEDIAN_VALID_EN
      check("reset_valid", bus.median_valid, 0);
`endif
      reset = 1'b0;
      model_reset();

      for (int i = 0; i < 14; i++) issue(dir_a[i]);

      reset_mid_sample(16'd999);

      for (int i = 14; i < 19; i++) issue(dir_a[i]);

      // Random stream with extremes and heavy duplication.
      for (int i = 0; i < 60; i++) begin
         k = $urandom_range(0, 4);
         case (k)
            0:       s = '0;
            1:       s = '1;
            2, 3:    s = DATA_W'($urandom_range(0, 7));
            default: s = DATA_W'($urandom_range(0, 65535));
         endcase
         if (i == 30) reset_mid_sample(DATA_W'($urandom));
         issue(s);
      end

      // Drain: bounded wait for the monitor to consume everything.
      k = 0;
      while (sb.size() != 0 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("drain", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_median_filter_fifo
